// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3 message transmitter.
//   W           data word width in bits (W/8 byte lanes)
//   RATE_WORDS  words per rate block (17 words = 136 bytes, SHA3-256)
//   DSUF        domain-separation / pad-start byte
//   tx_state_t  transmitter FSM states
package sha3_pkg;

   localparam int          W          = 64;
   localparam int          BYTES      = W / 8;
   localparam int          RATE_WORDS = 17;
   localparam logic [7:0]  DSUF       = 8'h06;
   localparam int          CNT_W      = $clog2(RATE_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      STREAM,
      PAD,
      WAIT_DONE,
      DONE
   } tx_state_t;

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational byte-lane masker / pad inserter.
//   data      input word, little-endian byte lanes
//   n         number of data bytes kept (0..8); lanes >= n are cleared
//   ins_dsuf  place DSUF in lane n (only meaningful when n < 8)
//   set_end   OR 0x80 into the top lane (rate-block end marker)
//   word      resulting padded word
module sha3_pad_word
   import sha3_pkg::*;
(
   input  logic [W-1:0] data,
   input  logic [3:0]   n,
   input  logic         ins_dsuf,
   input  logic         set_end,
   output logic [W-1:0] word
);

   always_comb begin
      word = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (i < int'(n)) begin
            word[8*i +: 8] = data[8*i +: 8];
         end else if (ins_dsuf && (i == int'(n))) begin
            word[8*i +: 8] = DSUF;
         end
      end
      // The end marker may share the top lane with DSUF (0x86 case).
      if (set_end) begin
         word[W-1 -: 8] = word[W-1 -: 8] | 8'h80;
      end
   end

endmodule

// File: rtl/sha3_msg_tx.sv
// Transmitter side of the SHA3 core message-load handshake.
// Streams upstream words to the core, appends SHA3 padding up to the
// rate boundary, then waits for the digest.
//   clk, rst      clock, asynchronous active-high reset
//   cmd_start     begin a new message (sampled in IDLE only)
//   in_*          upstream word stream; in_bytes valid on in_last
//   core_start    one-cycle start pulse to the core
//   core_valid    core is accepting words
//   core_we/wdata registered word write to the core
//   core_first    write belongs to rate block 0
//   core_last     final padded word of the message
//   core_ready    digest complete
//   busy/done/err status; done and err are sticky until reset
//
// Handshake: an upstream word transfers on a rising edge where
// in_valid && in_ready; in_ready is high only in STREAM while the core
// shows core_valid. Any word decided in a cycle with core_valid=1 is
// presented on core_we/core_wdata in the following cycle, and the core
// must take it.
module sha3_msg_tx
   import sha3_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_start,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   input  logic [3:0]   in_bytes,
   output logic         core_start,
   input  logic         core_valid,
   output logic         core_we,
   output logic [W-1:0] core_wdata,
   output logic         core_first,
   output logic         core_last,
   input  logic         core_ready,
   output logic         busy,
   output logic         done,
   output logic         err
);

   tx_state_t          state, state_nxt;
   logic [CNT_W-1:0]   word_cnt;
   logic               blk_cnt;
   logic               pad_pend, pend_nxt;

   logic               accept, bad_n, at_end;
   logic [3:0]         eff_n;
   logic               issue, wr_last;
   logic [W-1:0]       pw_data, pw_word;
   logic [3:0]         pw_n;
   logic               pw_ins, pw_end;

   assign accept = (state == STREAM) && in_valid && core_valid;
   assign bad_n  = in_last && ((in_bytes == 4'd0) || (in_bytes > 4'd8));
   // Non-final words and malformed byte counts are both full words.
   assign eff_n  = (!in_last || bad_n) ? 4'd8 : in_bytes;
   assign at_end = (word_cnt == CNT_W'(RATE_WORDS - 1));

   assign in_ready   = (state == STREAM) && core_valid;
   assign core_start = (state == START);
   assign busy       = (state == START) || (state == STREAM) ||
                       (state == PAD)   || (state == WAIT_DONE);
   assign done       = (state == DONE);

   sha3_pad_word u_pad (
      .data     (pw_data),
      .n        (pw_n),
      .ins_dsuf (pw_ins),
      .set_end  (pw_end),
      .word     (pw_word)
   );

   always_comb begin
      state_nxt = state;
      pend_nxt  = pad_pend;
      issue     = 1'b0;
      wr_last   = 1'b0;
      pw_data   = in_data;
      pw_n      = 4'd8;
      pw_ins    = 1'b0;
      pw_end    = 1'b0;
      case (state)
         IDLE:      if (cmd_start) state_nxt = START;
         START:     state_nxt = STREAM;
         STREAM: begin
            if (accept) begin
               issue = 1'b1;
               if (in_last) begin
                  if (eff_n < 4'd8) begin
                     pw_n   = eff_n;
                     pw_ins = 1'b1;
                     if (at_end) begin
                        pw_end    = 1'b1;
                        wr_last   = 1'b1;
                        state_nxt = WAIT_DONE;
                     end else begin
                        state_nxt = PAD;
                     end
                  end else begin
                     // Full last word: DSUF rides in lane 0 of the next
                     // word, which may open a whole extra block.
                     pend_nxt  = 1'b1;
                     state_nxt = PAD;
                  end
               end
            end
         end
         PAD: begin
            if (core_valid) begin
               issue    = 1'b1;
               pw_data  = '0;
               pw_n     = 4'd0;
               pw_ins   = pad_pend;
               pend_nxt = 1'b0;
               if (at_end) begin
                  pw_end    = 1'b1;
                  wr_last   = 1'b1;
                  state_nxt = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: if (core_ready) state_nxt = DONE;
         DONE:      state_nxt = DONE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         word_cnt   <= '0;
         blk_cnt    <= 1'b0;
         pad_pend   <= 1'b0;
         core_we    <= 1'b0;
         core_wdata <= '0;
         core_first <= 1'b0;
         core_last  <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         pad_pend   <= pend_nxt;
         core_we    <= issue;
         core_first <= issue && !blk_cnt;
         core_last  <= wr_last;
         if (issue) begin
            core_wdata <= pw_word;
            if (at_end) begin
               word_cnt <= '0;
               blk_cnt  <= 1'b1;
            end else begin
               word_cnt <= word_cnt + CNT_W'(1);
            end
         end
         if (accept && bad_n) err <= 1'b1;
      end
   end

endmodule
